// File: rtl/local_inject_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module   : local_inject_arbiter_if
// Purpose  : Source-side and switch-side AXI-stream bundle of the injection arbiter.
// Revision : 1.0
// ============================================================================
interface local_inject_arbiter_if #(
  parameter int BW      = 32,
  parameter int BWB     = BW / 8,
  parameter int NUM_REQ = 2
);
  logic [NUM_REQ-1:0]     s_TVALID;
  logic [NUM_REQ*BW-1:0]  s_TDATA;
  logic [NUM_REQ*BWB-1:0] s_TKEEP;
  logic [NUM_REQ-1:0]     s_TLAST;
  logic [NUM_REQ-1:0]     s_TREADY;
  logic                   m_TVALID;
  logic [BW-1:0]          m_TDATA;
  logic [BWB-1:0]         m_TKEEP;
  logic                   m_TLAST;
  logic                   m_TREADY;

  // slave: the arbiter's view; master: the sources plus switch surrounding it
  modport slave (
    input  s_TVALID, s_TDATA, s_TKEEP, s_TLAST, m_TREADY,
    output s_TREADY, m_TVALID, m_TDATA, m_TKEEP, m_TLAST
  );
  modport master (
    output s_TVALID, s_TDATA, s_TKEEP, s_TLAST, m_TREADY,
    input  s_TREADY, m_TVALID, m_TDATA, m_TKEEP, m_TLAST
  );
endinterface
`default_nettype wire

// File: rtl/local_inject_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : local_inject_arbiter
// Purpose  : Packet-atomic round-robin arbiter for the tile's local NoC injection port.
// Revision : 1.0
// ============================================================================
module local_inject_arbiter #(
  parameter int BW      = 32,
  parameter int BWB     = BW / 8,
  parameter int NUM_REQ = 2,
  parameter int CNT_W   = 16
) (
  input  wire                        clk_line,
  input  wire                        clk_line_rst_low,
  input  wire                        arb_enable,
  local_inject_arbiter_if.slave      bus,
  output logic [NUM_REQ-1:0]         grant,
  output logic                       busy,
  output logic [NUM_REQ*CNT_W-1:0]   pkt_count
);

  localparam int c_PW = $clog2(NUM_REQ);

  if (NUM_REQ < 2 || NUM_REQ > 4) begin : g_bad_num_req
    $error("local_inject_arbiter: NUM_REQ must be 2..4");
  end

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  state_t                     r_state;
  logic [c_PW-1:0]            r_rr_ptr;
  logic [c_PW-1:0]            r_gidx;
  logic [NUM_REQ-1:0]         r_grant;
  logic [NUM_REQ*CNT_W-1:0]   r_pkt_count;

  logic                       w_found;
  logic [c_PW-1:0]            w_sel;
  logic [c_PW:0]              w_sum;
  logic [c_PW-1:0]            w_next_ptr;
  logic                       w_last_acc;
  logic [NUM_REQ-1:0]         w_tready;

  // Round-robin search starting at r_rr_ptr; one subtraction wraps since both terms are < NUM_REQ
  always_comb begin
    w_found = 1'b0;
    w_sel   = '0;
    w_sum   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_sum = {1'b0, r_rr_ptr} + (c_PW+1)'(k);
      if (w_sum >= (c_PW+1)'(NUM_REQ)) begin
        w_sum = w_sum - (c_PW+1)'(NUM_REQ);
      end
      if (!w_found && bus.s_TVALID[w_sum[c_PW-1:0]]) begin
        w_found = 1'b1;
        w_sel   = w_sum[c_PW-1:0];
      end
    end
  end

  assign w_next_ptr = (r_gidx == c_PW'(NUM_REQ - 1)) ? '0 : r_gidx + c_PW'(1);

  assign bus.m_TVALID = (r_state == ST_BUSY) ? bus.s_TVALID[r_gidx]               : 1'b0;
  assign bus.m_TDATA  = (r_state == ST_BUSY) ? bus.s_TDATA[r_gidx*BW +: BW]        : '0;
  assign bus.m_TKEEP  = (r_state == ST_BUSY) ? bus.s_TKEEP[r_gidx*BWB +: BWB]      : '0;
  assign bus.m_TLAST  = (r_state == ST_BUSY) ? bus.s_TLAST[r_gidx]                : 1'b0;

  always_comb begin
    w_tready = '0;
    if (r_state == ST_BUSY) begin
      w_tready[r_gidx] = bus.m_TREADY;
    end
  end
  assign bus.s_TREADY = w_tready;

  assign w_last_acc = bus.m_TVALID & bus.m_TREADY & bus.m_TLAST;

  always_ff @(posedge clk_line or negedge clk_line_rst_low) begin
    if (!clk_line_rst_low) begin
      r_state     <= ST_IDLE;
      r_rr_ptr    <= '0;
      r_gidx      <= '0;
      r_grant     <= '0;
      r_pkt_count <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (arb_enable && w_found) begin
            r_state <= ST_BUSY;
            r_gidx  <= w_sel;
            r_grant <= NUM_REQ'(1) << w_sel;
          end
        end
        ST_BUSY: begin
          // Ownership is released only on the accepted TLAST beat
          if (w_last_acc) begin
            r_state  <= ST_IDLE;
            r_grant  <= '0;
            r_rr_ptr <= w_next_ptr;
            r_pkt_count[r_gidx*CNT_W +: CNT_W] <= r_pkt_count[r_gidx*CNT_W +: CNT_W] + CNT_W'(1);
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign grant     = r_grant;
  assign busy      = (r_state == ST_BUSY);
  assign pkt_count = r_pkt_count;

endmodule
`default_nettype wire

// File: tb/tb_local_inject_arbiter.sv
`default_nettype none
// Testbench for local_inject_arbiter: scoreboarded beats, table-driven arbitration
// vectors and hand-written multi-cycle corner cases.
module tb_local_inject_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        arb_enable;
  logic [1:0]  grant;
  logic        busy;
  logic [31:0] pkt_count;
  logic [1:0]  w_grant;
  logic        w_busy;
  logic [7:0]  w_pkt;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  local_inject_arbiter_if #(.BW(32), .BWB(4), .NUM_REQ(2)) bus ();
  local_inject_arbiter_if #(.BW(32), .BWB(4), .NUM_REQ(2)) wbus ();

  local_inject_arbiter #(.BW(32), .BWB(4), .NUM_REQ(2), .CNT_W(16)) dut (
    .clk_line(clk), .clk_line_rst_low(rst_n), .arb_enable(arb_enable),
    .bus(bus), .grant(grant), .busy(busy), .pkt_count(pkt_count)
  );

  // Narrow-counter instance for the counter wrap check
  local_inject_arbiter #(.BW(32), .BWB(4), .NUM_REQ(2), .CNT_W(4)) u_wrap (
    .clk_line(clk), .clk_line_rst_low(rst_n), .arb_enable(1'b1),
    .bus(wbus), .grant(w_grant), .busy(w_busy), .pkt_count(w_pkt)
  );

  typedef struct {
    logic [31:0] data;
    logic [3:0]  keep;
    logic        last;
  } beat_t;

  beat_t q0[$], q1[$], e0[$], e1[$];
  logic  hold0 = 1'b0, hold1 = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int src, input int n, input logic [7:0] base);
    beat_t b;
    for (int k = 0; k < n; k++) begin
      b.data = {24'h0, base + 8'(k)};
      b.keep = (k % 2 == 1) ? 4'h3 : 4'hF;
      b.last = (k == n - 1);
      if (src == 0) begin q0.push_back(b); e0.push_back(b); end
      else          begin q1.push_back(b); e1.push_back(b); end
    end
  endtask

  task automatic drive_src();
    bus.s_TVALID = '0; bus.s_TDATA = '0; bus.s_TKEEP = '0; bus.s_TLAST = '0;
    if (q0.size() > 0) begin
      bus.s_TVALID[0]    = !hold0;
      bus.s_TDATA[31:0]  = q0[0].data;
      bus.s_TKEEP[3:0]   = q0[0].keep;
      bus.s_TLAST[0]     = q0[0].last;
    end
    if (q1.size() > 0) begin
      bus.s_TVALID[1]    = !hold1;
      bus.s_TDATA[63:32] = q1[0].data;
      bus.s_TKEEP[7:4]   = q1[0].keep;
      bus.s_TLAST[1]     = q1[0].last;
    end
  endtask

  // Source driver: a head beat is retired one edge after it was seen accepted
  initial begin
    logic a0, a1;
    drive_src();
    forever begin
      @(negedge clk);
      a0 = bus.s_TVALID[0] && bus.s_TREADY[0];
      a1 = bus.s_TVALID[1] && bus.s_TREADY[1];
      @(posedge clk);
      #2;
      if (a0 && q0.size() > 0) void'(q0.pop_front());
      if (a1 && q1.size() > 0) void'(q1.pop_front());
      drive_src();
    end
  end

  // Output monitor: every accepted beat must match the owner's next expected beat
  logic [1:0] own = 2'b00;
  logic       in_pkt = 1'b0;
  beat_t      eb;
  always @(negedge clk) begin
    if (!rst_n) begin
      in_pkt = 1'b0;
    end else if (bus.m_TVALID && bus.m_TREADY) begin
      if (in_pkt) chk("no_interleave", grant, own);
      own    = grant;
      in_pkt = !bus.m_TLAST;
      if (grant == 2'b01 && e0.size() > 0) begin
        eb = e0.pop_front();
      end else if (grant == 2'b10 && e1.size() > 0) begin
        eb = e1.pop_front();
      end else begin
        total++; bad++;
        $display("FAIL unexpected_beat: grant=%b data=%0h with no beat expected", grant, bus.m_TDATA);
        eb.data = bus.m_TDATA; eb.keep = bus.m_TKEEP; eb.last = bus.m_TLAST;
      end
      chk("beat_data", bus.m_TDATA, eb.data);
      chk("beat_keep", bus.m_TKEEP, eb.keep);
      chk("beat_last", bus.m_TLAST, eb.last);
    end
  end

  typedef struct {
    logic [1:0] add;
    logic       en;
    logic [1:0] exp_grant;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t       vt[10];
    logic [1:0] alt[4];

    vt[0] = '{2'b11, 1'b1, 2'b10};
    vt[1] = '{2'b00, 1'b1, 2'b01};
    vt[2] = '{2'b01, 1'b1, 2'b01};
    vt[3] = '{2'b10, 1'b1, 2'b10};
    vt[4] = '{2'b11, 1'b0, 2'b00};
    vt[5] = '{2'b00, 1'b1, 2'b01};
    vt[6] = '{2'b01, 1'b1, 2'b10};
    vt[7] = '{2'b00, 1'b1, 2'b01};
    vt[8] = '{2'b10, 1'b1, 2'b10};
    vt[9] = '{2'b00, 1'b1, 2'b00};
    alt[0] = 2'b01; alt[1] = 2'b10; alt[2] = 2'b01; alt[3] = 2'b10;

    rst_n = 1'b0; arb_enable = 1'b0; bus.m_TREADY = 1'b0;
    wbus.s_TVALID = 2'b00; wbus.s_TDATA = '0; wbus.s_TKEEP = '1;
    wbus.s_TLAST = 2'b11; wbus.m_TREADY = 1'b1;
    repeat (3) step();
    chk("rst_grant", grant, 2'b00);
    chk("rst_busy", busy, 1'b0);
    chk("rst_pkt_count", pkt_count, 32'h0);
    chk("rst_m_tvalid", bus.m_TVALID, 1'b0);
    chk("rst_s_tready", bus.s_TREADY, 2'b00);
    rst_n = 1'b1;
    step();

    // 3-beat packet from source 0
    arb_enable = 1'b1; bus.m_TREADY = 1'b1;
    send(0, 3, 8'hA0);
    step();
    chk("t1_grant", grant, 2'b01);
    chk("t1_busy", busy, 1'b1);
    @(negedge clk);
    chk("t1_first_data", bus.m_TDATA, 32'hA0);
    step(); step();
    chk("t1_grant_hold", grant, 2'b01);
    step();
    chk("t1_grant_end", grant, 2'b00);
    chk("t1_busy_end", busy, 1'b0);
    chk("t1_pkt_count", pkt_count, 32'h0000_0001);

    // Arbitration table of single-beat packets; rr pointer is 1 on entry
    for (int v = 0; v < 10; v++) begin
      if (vt[v].add[0]) send(0, 1, 8'h10 + 8'(v));
      if (vt[v].add[1]) send(1, 1, 8'h20 + 8'(v));
      arb_enable = vt[v].en;
      step();
      chk($sformatf("tbl%0d_grant", v), grant, vt[v].exp_grant);
      chk($sformatf("tbl%0d_busy", v), busy, |vt[v].exp_grant);
      if (vt[v].exp_grant != 2'b00) step();
    end
    chk("tbl_pkt_count", pkt_count, 32'h0004_0005);
    chk("tbl_drained", e0.size() + e1.size(), 0);

    // Both sources continuously valid with 2-beat packets
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    send(0, 2, 8'h30); send(0, 2, 8'h32);
    send(1, 2, 8'h40); send(1, 2, 8'h42);
    for (int p = 0; p < 4; p++) begin
      step();
      chk($sformatf("t2_grant%0d", p), grant, alt[p]);
      step(); step();
    end
    chk("t2_pkt_count", pkt_count, 32'h0002_0002);

    // Source 1 stalls mid-packet while source 0 waits
    send(1, 3, 8'h50);
    step();
    chk("t3_grant", grant, 2'b10);
    send(0, 2, 8'h60); hold1 = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("t3_s_tready0", bus.s_TREADY[0], 1'b0);
      chk("t3_m_tvalid", bus.m_TVALID, 1'b0);
      step();
      chk("t3_grant_held", grant, 2'b10);
    end
    hold1 = 1'b0;
    step(); step();
    chk("t3_grant_resume", grant, 2'b10);
    step();
    chk("t3_grant_release", grant, 2'b00);
    chk("t3_src1_done", e1.size(), 0);
    step();
    chk("t3_grant_src0", grant, 2'b01);
    step(); step();
    chk("t3_end", grant, 2'b00);

    // Switch back-pressure for 4 cycles on the first beat
    bus.m_TREADY = 1'b0;
    send(0, 2, 8'h70);
    step();
    chk("t4_grant", grant, 2'b01);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("t4_data_stable", bus.m_TDATA, 32'h70);
      chk("t4_m_tvalid", bus.m_TVALID, 1'b1);
      chk("t4_s_tready0", bus.s_TREADY[0], 1'b0);
      step();
    end
    bus.m_TREADY = 1'b1;
    step(); step();
    chk("t4_grant_end", grant, 2'b00);
    chk("t4_src0_done", e0.size(), 0);
    chk("t4_pkt_count", pkt_count, 32'h0003_0004);

    // Enable dropped during beat 2 of 4
    send(0, 4, 8'h80);
    step();
    chk("t5_grant", grant, 2'b01);
    send(1, 1, 8'h90); send(0, 1, 8'h88);
    step();
    arb_enable = 1'b0;
    step(); step();
    chk("t5_grant_hold", grant, 2'b01);
    step();
    chk("t5_grant_end", grant, 2'b00);
    for (int i = 0; i < 3; i++) begin
      step();
      chk("t5_idle_grant", grant, 2'b00);
      chk("t5_idle_busy", busy, 1'b0);
    end
    arb_enable = 1'b1;
    step();
    chk("t5_regrant", grant, 2'b10);
    step(); step();
    chk("t5_grant_next", grant, 2'b01);
    step();
    chk("t5_pkt_count", pkt_count, 32'h0004_0006);

    // Reset mid-packet
    send(0, 3, 8'hB0);
    step();
    chk("t6_grant", grant, 2'b01);
    step();
    rst_n = 1'b0;
    #1;
    chk("t6_rst_grant", grant, 2'b00);
    chk("t6_rst_busy", busy, 1'b0);
    chk("t6_rst_m_tvalid", bus.m_TVALID, 1'b0);
    chk("t6_rst_s_tready", bus.s_TREADY, 2'b00);
    chk("t6_rst_pkt_count", pkt_count, 32'h0);
    q0.delete(); e0.delete();
    step(); step();
    rst_n = 1'b1;
    step();

    // Counter wrap on a 4-bit counter: single-beat packets every 2 cycles
    chk("wrap_start", w_pkt, 8'h00);
    wbus.s_TVALID = 2'b01;
    repeat (30) step();
    chk("wrap_max", w_pkt, 8'h0F);
    step(); step();
    chk("wrap_zero", w_pkt, 8'h00);
    wbus.s_TVALID = 2'b00;
    step(); step();

    chk("final_src0_drained", e0.size(), 0);
    chk("final_src1_drained", e1.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/local_inject_arbiter.md
Name: local_inject_arbiter

Overview:
- Packet-atomic round-robin arbiter that shares the tile's single local NoC injection port (switch local_in) between up to 4 AXI-stream packet sources, e.g. accelerator core and AXI-control message path.
- Sits between the sources and the tile switch, in the line clock domain.
- Once granted, a source holds the port until its TLAST beat is accepted.
- Provides enable gating and per-source packet counters for debug and status.

Parameters:
- BW, 32, stream data width in bits.
- BWB, BW/8, TKEEP width.
- NUM_REQ, 2, number of requesters; legal range 2..4.
- CNT_W, 16, width of each per-source packet counter.

Ports:
- clk_line  in  1  line clock.
- clk_line_rst_low  in  1  asynchronous active-low reset.
- arb_enable  in  1  1 = new grants allowed; 0 = finish current packet, then hold idle.
- s_TVALID  in  NUM_REQ  per-source valid.
- s_TDATA  in  NUM_REQ*BW  per-source data; source i occupies slice [i*BW +: BW].
- s_TKEEP  in  NUM_REQ*BWB  per-source keep.
- s_TLAST  in  NUM_REQ  per-source last.
- s_TREADY  out  NUM_REQ  per-source ready.
- m_TVALID  out  1  valid to switch local_in.
- m_TDATA  out  BW  data to switch.
- m_TKEEP  out  BWB  keep to switch.
- m_TLAST  out  1  last to switch.
- m_TREADY  in  1  ready from switch.
- grant  out  NUM_REQ  one-hot current owner; all-zero when idle.
- busy  out  1  1 while in BUSY state.
- pkt_count  out  NUM_REQ*CNT_W  packets forwarded per source; source i occupies slice [i*CNT_W +: CNT_W].

Behaviour:

Reset (async assert, sync deassert handled upstream):
- state = IDLE.
- grant = 0, busy = 0.
- rr_ptr = 0.
- pkt_count all 0.
- m_TVALID = 0, s_TREADY all 0.

States:
- IDLE: m_TVALID = 0, s_TREADY = 0.
  - If arb_enable = 1 and any s_TVALID = 1: select the first valid source searching rr_ptr, rr_ptr+1, ..., wrapping modulo NUM_REQ.
  - Register the selection into grant and go to BUSY next cycle.
  - Arbitration costs exactly 1 bubble cycle per packet.
- BUSY: datapath is combinational from the granted source g.
  - m_TVALID = s_TVALID[g].
  - m_TDATA, m_TKEEP, m_TLAST = source g slices.
  - s_TREADY[g] = m_TREADY; all other s_TREADY = 0.
  - A beat is accepted when m_TVALID and m_TREADY are both 1.
  - On an accepted beat with m_TLAST = 1:
    - pkt_count[g] increments, wrapping at 2^CNT_W.
    - rr_ptr = (g+1) mod NUM_REQ.
    - grant = 0, state = IDLE.

Boundary conditions:
- Single-beat packet (TLAST on the first beat): same flow; the owner can re-win after 1 idle cycle only if no other source is valid.
- Source g deasserts TVALID mid-packet: grant is held; no other source may interleave.
- arb_enable falls in BUSY: the current packet completes normally; IDLE then issues no new grant until arb_enable = 1.
- arb_enable falls in the same cycle IDLE would grant: no grant is issued.
- Non-granted sources are never dropped; their TVALID stays pending.
- Reset mid-packet: all state is cleared immediately, the partial packet is abandoned, and grant is 0. Downstream recovery is the switch's concern.
- No timeout: a stalled owner blocks the port indefinitely.
- Outputs m_TDATA, m_TKEEP and m_TLAST are don't-care when m_TVALID = 0 but driven to 0 in IDLE.

Test Plan:
1. Reset, arb_enable = 1, source0 sends a 3-beat packet (0xA0, 0xA1, 0xA2 with TLAST on the third), m_TREADY = 1:
   - grant = 01 on cycle 1.
   - Beats appear on cycles 1-3.
   - pkt_count[0] = 1, rr_ptr = 1, grant = 0 on cycle 4.
2. Both sources continuously valid with 2-beat packets, NUM_REQ = 2:
   - Grants alternate 01, 10, 01, 10.
   - No beat interleaving.
   - After 4 packets pkt_count = {2, 2}.
3. Source1 owns the port and drops TVALID for 5 cycles mid-packet while source0 is valid:
   - grant stays 10.
   - s_TREADY[0] = 0 throughout.
   - Source1's packet completes before source0 is granted.
4. m_TREADY = 0 for 4 cycles during a beat:
   - m_TDATA stays stable.
   - s_TREADY[g] = 0.
   - The beat is transferred exactly once when m_TREADY rises.
5. arb_enable cleared during beat 2 of 4:
   - The packet finishes.
   - Then grant = 0 and busy = 0 while source0/1 stay valid.
   - Re-enabling yields a grant 1 cycle later.
6. Assert clk_line_rst_low = 0 mid-packet, with pkt_count[0] preloaded to 0xFFFF via 65535 packets, or a forced wrap check:
   - All outputs return to 0 immediately.
   - Separately, a 65536th packet wraps pkt_count[0] to 0x0000.
